// File: rtl/execute_mc.sv
// execute_mc: integer execute stage with operand forwarding and iterative multiply/divide
module execute_mc #(
    parameter int XLEN    = 64,
    parameter int NUM_FWD = 2,
    parameter int LG      = $clog2(XLEN)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [3:0]                     in_op,
    input  logic [4:0]                     in_rs1_addr,
    input  logic [4:0]                     in_rs2_addr,
    input  logic [XLEN-1:0]                in_rs1_val,
    input  logic [XLEN-1:0]                in_rs2_val,
    input  logic                           in_use_imm,
    input  logic [XLEN-1:0]                in_imm,
    input  logic [4:0]                     in_rd,
    input  logic [NUM_FWD-1:0]             fwd_en,
    input  logic [NUM_FWD-1:0][4:0]        fwd_addr,
    input  logic [NUM_FWD-1:0][XLEN-1:0]   fwd_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [XLEN-1:0]                out_result,
    output logic [4:0]                     out_rd,
    output logic                           busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_d;
    logic [LG-1:0]   cnt;
    logic [3:0]      op_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] rem, wk, dv;
    logic            neg_q, neg_r;
    logic [XLEN-1:0] opa, fwd_b, opb, alu, mc_res, diff;
    logic [XLEN:0]   t;
    logic [LG-1:0]   sh;
    logic            accept, multi, last, ge, a_neg, b_neg;
    assign in_ready = (state == IDLE) & (!out_valid | out_ready) & !flush;
    assign accept   = in_valid & in_ready;
    assign multi    = (in_op == 4'd10) | (in_op >= 4'd12);
    assign last     = cnt == LG'(XLEN - 1);
    assign busy     = state != IDLE;
    assign opb      = in_use_imm ? in_imm : fwd_b;
    assign sh       = opb[LG-1:0];
    assign a_neg    = !in_op[0] & opa[XLEN-1];
    assign b_neg    = !in_op[0] & opb[XLEN-1];
    assign t        = {rem, wk[XLEN-1]};
    assign ge       = t >= {1'b0, dv};
    assign diff     = t[XLEN-1:0] - dv;
    // operand selection: lowest-numbered matching forward channel wins, register 0 never forwards
    always_comb begin
        opa   = in_rs1_val;
        fwd_b = in_rs2_val;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_en[i] && fwd_addr[i] == in_rs1_addr && fwd_addr[i] != 5'd0) opa = fwd_data[i];
            if (fwd_en[i] && fwd_addr[i] == in_rs2_addr && fwd_addr[i] != 5'd0) fwd_b = fwd_data[i];
        end
    end
    // single-cycle ALU
    always_comb begin
        case (in_op)
            4'd0:    alu = opa + opb;
            4'd1:    alu = opa - opb;
            4'd2:    alu = opa & opb;
            4'd3:    alu = opa | opb;
            4'd4:    alu = opa ^ opb;
            4'd5:    alu = opa << sh;
            4'd6:    alu = opa >> sh;
            4'd7:    alu = $signed(opa) >>> sh;
            4'd8:    alu = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb)};
            4'd9:    alu = {{(XLEN-1){1'b0}}, opa < opb};
            4'd11:   alu = opb;
            default: alu = '0;
        endcase
    end
    // final multi-cycle result with sign fix-up of quotient/remainder magnitudes
    always_comb begin
        mc_res = (op_q == 4'd10) ? rem :
                 (op_q[3:1] == 3'b111) ? (neg_r ? -rem : rem) :
                 (neg_q ? -wk : wk);
    end
    // next-state logic; flush always returns to IDLE
    always_comb begin
        state_d = flush ? IDLE :
                  (state == IDLE) ? ((accept && multi) ? CALC : IDLE) :
                  (state == CALC) ? (last ? DONE : CALC) : IDLE;
    end
    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end
    // output register and iteration datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            cnt        <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            rem        <= '0;
            wk         <= '0;
            dv         <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            if (accept && !multi) begin
                out_valid  <= 1'b1;
                out_result <= alu;
                out_rd     <= in_rd;
            end else if (state == DONE) begin
                out_valid  <= 1'b1;
                out_result <= mc_res;
                out_rd     <= rd_q;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && multi) begin
                op_q  <= in_op;
                rd_q  <= in_rd;
                cnt   <= '0;
                rem   <= '0;
                wk    <= (in_op == 4'd10) ? opb : (a_neg ? -opa : opa);
                dv    <= (in_op == 4'd10) ? opa : (b_neg ? -opb : opb);
                neg_q <= (a_neg ^ b_neg) & (|opb);
                neg_r <= a_neg;
            end else if (state == CALC) begin
                cnt <= cnt + 1'b1;
                if (op_q == 4'd10) begin
                    rem <= wk[0] ? rem + dv : rem;
                    dv  <= dv << 1;
                    wk  <= wk >> 1;
                end else begin
                    rem <= ge ? diff : t[XLEN-1:0];
                    wk  <= {wk[XLEN-2:0], ge};
                end
            end
        end
    end
endmodule

// File: tb/tb_execute_mc.sv
// tb_execute_mc: directed self-checking bench for execute_mc
module tb_execute_mc;
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, XOR = 4'd4, SLL = 4'd5, SRL = 4'd6, SRA = 4'd7;
    localparam logic [3:0] SLT = 4'd8, SLTU = 4'd9, MUL = 4'd10, PASSB = 4'd11;
    localparam logic [3:0] DIV = 4'd12, DIVU = 4'd13, REM = 4'd14, REMU = 4'd15;
    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000, ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    logic clk = 0, reset = 0, flush = 0, in_valid = 0, in_ready, in_use_imm = 0;
    logic [3:0] in_op = 0;
    logic [4:0] in_rs1_addr = 0, in_rs2_addr = 0, in_rd = 0, out_rd;
    logic [63:0] in_rs1_val = 0, in_rs2_val = 0, in_imm = 0, out_result;
    logic [1:0] fwd_en = 0;
    logic [1:0][4:0] fwd_addr = '0;
    logic [1:0][63:0] fwd_data = '0;
    logic out_valid, out_ready = 1, busy;
    int vec = 0, miscompares = 0;

    execute_mc dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_use_imm(in_use_imm),
        .in_imm(in_imm), .in_rd(in_rd), .fwd_en(fwd_en), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic set_req(input logic [3:0] op, input logic [4:0] ra, input logic [63:0] va,
                           input logic [4:0] rb, input logic [63:0] vb, input logic ui,
                           input logic [63:0] imm, input logic [4:0] rd);
        in_op = op; in_rs1_addr = ra; in_rs1_val = va; in_rs2_addr = rb; in_rs2_val = vb;
        in_use_imm = ui; in_imm = imm; in_rd = rd;
    endtask

    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
        set_req(op, 5'd0, a, 5'd0, b, 1'b0, 64'd0, rd);
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic wait_result(output int lat, output bit busy_ok);
        lat = 1;
        busy_ok = 1;
        while (!out_valid && lat < 200) begin
            if (!busy || in_ready) busy_ok = 0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        #3;
        vec++; if (out_valid !== 0 || busy !== 0 || out_result !== 0 || out_rd !== 0) begin
            miscompares++; $display("FAIL reset_outputs got v=%b b=%b r=%h rd=%0d want all 0", out_valid, busy, out_result, out_rd); end
        @(negedge clk); reset = 1;
        @(negedge clk);
        vec++; if (in_ready !== 1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_add_imm;
        set_req(ADD, 5'd0, 64'd5, 5'd0, 64'd0, 1'b1, -64'sd7, 5'd9);
        in_valid = 1; @(negedge clk); in_valid = 0;
        vec++; if (out_valid !== 1 || out_result !== 64'hFFFF_FFFF_FFFF_FFFE || out_rd !== 5'd9) begin
            miscompares++; $display("FAIL add_imm got v=%b %h rd=%0d want 1 fffffffffffffffe 9", out_valid, out_result, out_rd); end
        @(negedge clk);
        vec++; if (out_valid !== 0) begin miscompares++; $display("FAIL add_imm_clear got %b want 0", out_valid); end
    endtask

    task automatic test_fwd;
        fwd_en = 2'b11; fwd_addr[0] = 5'd3; fwd_data[0] = 64'h11; fwd_addr[1] = 5'd3; fwd_data[1] = 64'h22;
        set_req(ADD, 5'd3, 64'h99, 5'd0, 64'd0, 1'b1, 64'd0, 5'd1);
        in_valid = 1; @(negedge clk);
        vec++; if (out_result !== 64'h11) begin miscompares++; $display("FAIL fwd_priority got %h want 11", out_result); end
        fwd_en = 2'b10; @(negedge clk);
        vec++; if (out_result !== 64'h22) begin miscompares++; $display("FAIL fwd_ch1 got %h want 22", out_result); end
        fwd_en = 2'b01; fwd_addr[0] = 5'd0; fwd_data[0] = 64'h99;
        set_req(ADD, 5'd0, 64'h55, 5'd0, 64'd0, 1'b1, 64'd0, 5'd1); @(negedge clk);
        vec++; if (out_result !== 64'h55) begin miscompares++; $display("FAIL fwd_r0 got %h want 55", out_result); end
        fwd_en = 2'b10; fwd_addr[1] = 5'd4; fwd_data[1] = 64'h77;
        set_req(PASSB, 5'd0, 64'd0, 5'd4, 64'h33, 1'b0, 64'd5, 5'd1); @(negedge clk);
        vec++; if (out_result !== 64'h77) begin miscompares++; $display("FAIL fwd_b got %h want 77", out_result); end
        in_use_imm = 1; @(negedge clk);
        vec++; if (out_result !== 64'h5) begin miscompares++; $display("FAIL fwd_b_imm got %h want 5", out_result); end
        in_valid = 0; fwd_en = 0; @(negedge clk);
    endtask

    task automatic test_alu;
        issue(SUB, 64'd10, 64'd3, 5'd2);
        vec++; if (out_result !== 64'd7) begin miscompares++; $display("FAIL sub got %h want 7", out_result); end
        issue(SLL, 64'd1, 64'd65, 5'd2);
        vec++; if (out_result !== 64'd2) begin miscompares++; $display("FAIL sll_mask got %h want 2", out_result); end
        issue(SRA, MIN, 64'd4, 5'd2);
        vec++; if (out_result !== 64'hF800_0000_0000_0000) begin miscompares++; $display("FAIL sra got %h want f800000000000000", out_result); end
        issue(SRL, MIN, 64'd63, 5'd2);
        vec++; if (out_result !== 64'd1) begin miscompares++; $display("FAIL srl got %h want 1", out_result); end
        issue(SLT, ONES, 64'd1, 5'd2);
        vec++; if (out_result !== 64'd1) begin miscompares++; $display("FAIL slt got %h want 1", out_result); end
        issue(SLTU, ONES, 64'd1, 5'd2);
        vec++; if (out_result !== 64'd0) begin miscompares++; $display("FAIL sltu got %h want 0", out_result); end
        issue(XOR, 64'hF0, 64'hFF, 5'd2);
        vec++; if (out_result !== 64'h0F) begin miscompares++; $display("FAIL xor got %h want f", out_result); end
    endtask

    task automatic test_div;
        logic [3:0] ops [7] = '{DIV, REM, DIVU, REMU, DIV, REM, DIV};
        logic [63:0] as [7] = '{-64'sd20, -64'sd20, 64'd7, 64'd7, MIN, MIN, -64'sd5};
        logic [63:0] bs [7] = '{64'd3, 64'd3, 64'd0, 64'd0, ONES, ONES, 64'd0};
        logic [63:0] ex [7] = '{-64'sd6, -64'sd2, ONES, 64'd7, MIN, 64'd0, ONES};
        int lat;
        bit bok;
        for (int i = 0; i < 7; i++) begin
            issue(ops[i], as[i], bs[i], 5'd7);
            wait_result(lat, bok);
            vec++; if (lat != 66) begin miscompares++; $display("FAIL div%0d_latency got %0d want 66", i, lat); end
            vec++; if (out_result !== ex[i] || out_rd !== 5'd7) begin
                miscompares++; $display("FAIL div%0d_result got %h rd=%0d want %h rd=7", i, out_result, out_rd, ex[i]); end
            vec++; if (!bok) begin miscompares++; $display("FAIL div%0d_busy got low busy or high in_ready want busy=1 in_ready=0", i); end
            @(negedge clk);
        end
        issue(DIVU, 64'd100, 64'd7, 5'd3); wait_result(lat, bok);
        vec++; if (out_result !== 64'd14) begin miscompares++; $display("FAIL divu got %h want e", out_result); end
        @(negedge clk);
    endtask

    task automatic test_mul;
        int lat;
        bit bok;
        issue(MUL, ONES, 64'd3, 5'd8); wait_result(lat, bok);
        vec++; if (lat != 66 || !bok || out_result !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            miscompares++; $display("FAIL mul_neg got %h lat=%0d busy_ok=%b want fffffffffffffffd lat=66 busy_ok=1", out_result, lat, bok); end
        vec++; if (busy !== 0 || in_ready !== 1) begin miscompares++; $display("FAIL mul_done got busy=%b in_ready=%b want 0 1", busy, in_ready); end
        @(negedge clk);
        issue(MUL, 64'd6, 64'd7, 5'd8); wait_result(lat, bok);
        vec++; if (out_result !== 64'd42) begin miscompares++; $display("FAIL mul_small got %h want 2a", out_result); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int bad = 0;
        out_ready = 0;
        issue(ADD, 64'd1, 64'd2, 5'd4);
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1 || out_result !== 64'd3 || out_rd !== 5'd4 || in_ready !== 0) bad++;
            @(negedge clk);
        end
        vec++; if (bad != 0) begin miscompares++; $display("FAIL hold got %0d bad cycles want 0", bad); end
        out_ready = 1;
        set_req(ADD, 5'd0, 64'd10, 5'd0, 64'd0, 1'b1, 64'd20, 5'd5); in_valid = 1;
        #1;
        vec++; if (in_ready !== 1) begin miscompares++; $display("FAIL release_ready got %b want 1", in_ready); end
        @(negedge clk);
        vec++; if (out_valid !== 1 || out_result !== 64'd30 || out_rd !== 5'd5) begin
            miscompares++; $display("FAIL no_bubble got v=%b %h rd=%0d want 1 1e 5", out_valid, out_result, out_rd); end
        in_imm = 64'd21; @(negedge clk);
        vec++; if (out_valid !== 1 || out_result !== 64'd31) begin miscompares++; $display("FAIL b2b got v=%b %h want 1 1f", out_valid, out_result); end
        in_valid = 0; @(negedge clk);
    endtask

    task automatic test_flush;
        int bad = 0;
        issue(MUL, 64'd5, 64'd5, 5'd6);
        repeat (10) @(negedge clk);
        flush = 1; @(negedge clk); flush = 0; #1;
        vec++; if (in_ready !== 1 || busy !== 0 || out_valid !== 0) begin
            miscompares++; $display("FAIL flush_calc got rdy=%b busy=%b v=%b want 1 0 0", in_ready, busy, out_valid); end
        repeat (70) begin @(negedge clk); if (out_valid) bad++; end
        vec++; if (bad != 0) begin miscompares++; $display("FAIL flush_discard got %0d valid cycles want 0", bad); end
        set_req(ADD, 5'd0, 64'd1, 5'd0, 64'd1, 1'b0, 64'd0, 5'd1); in_valid = 1; flush = 1;
        @(negedge clk); in_valid = 0; flush = 0;
        vec++; if (out_valid !== 0) begin miscompares++; $display("FAIL flush_accept got %b want 0", out_valid); end
        issue(MUL, 64'd5, 64'd5, 5'd6);
        repeat (64) @(negedge clk);
        vec++; if (busy !== 1 || out_valid !== 0) begin miscompares++; $display("FAIL pre_done got busy=%b v=%b want 1 0", busy, out_valid); end
        flush = 1; @(negedge clk); flush = 0;
        vec++; if (out_valid !== 0 || busy !== 0) begin miscompares++; $display("FAIL flush_done got v=%b busy=%b want 0 0", out_valid, busy); end
    endtask

    task automatic test_reset_mid_calc;
        issue(ADD, 64'd40, 64'd2, 5'd12);
        issue(MUL, 64'd3, 64'd3, 5'd13);
        repeat (5) @(negedge clk);
        #2 reset = 0; #1;
        vec++; if (out_valid !== 0 || busy !== 0 || out_result !== 0 || out_rd !== 0) begin
            miscompares++; $display("FAIL reset_mid got v=%b b=%b r=%h rd=%0d want all 0", out_valid, busy, out_result, out_rd); end
        @(negedge clk); reset = 1; @(negedge clk);
        vec++; if (in_ready !== 1 || busy !== 0) begin miscompares++; $display("FAIL reset_release got rdy=%b busy=%b want 1 0", in_ready, busy); end
    endtask

    initial begin
        test_reset;
        test_add_imm;
        test_fwd;
        test_alu;
        test_div;
        test_mul;
        test_back_to_back;
        test_flush;
        test_reset_mid_calc;
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
        $finish;
    end
endmodule

// File: doc/execute_mc.md
EXECUTE_MC -- requirements
Module: execute_mc

Parameters
REQ-001 The block SHALL have parameter XLEN, default 64, meaning datapath width in bits (legal values 32 and 64).
REQ-002 The block SHALL have parameter NUM_FWD, default 2, meaning the number of forwarding channels, at least 1.
REQ-003 The block SHALL have parameter LG, fixed at $clog2(XLEN), meaning shift-amount width.

Interface
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 flush  in  1  abort the in-flight operation and discard any pending result.
REQ-007 in_valid  in  1  request valid.
REQ-008 in_ready  out  1  block can accept a request.
REQ-009 in_op  in  4  operation select, encoded 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 PASSB, 12 DIV, 13 DIVU, 14 REM, 15 REMU.
REQ-010 in_rs1_addr, in_rs2_addr  in  5 each  source register numbers.
REQ-011 in_rs1_val, in_rs2_val  in  XLEN each  register-file operand values.
REQ-012 in_use_imm  in  1  when set, operand B is taken from in_imm instead of rs2.
REQ-013 in_imm  in  XLEN  immediate value.
REQ-014 in_rd  in  5  destination register number.
REQ-015 fwd_en  in  NUM_FWD  per-channel forward valid.
REQ-016 fwd_addr  in  NUM_FWD x 5  per-channel destination register number.
REQ-017 fwd_data  in  NUM_FWD x XLEN  per-channel forward data.
REQ-018 out_valid  out  1  result valid.
REQ-019 out_ready  in  1  downstream accepts the result.
REQ-020 out_result  out  XLEN  result value.
REQ-021 out_rd  out  5  destination register of the result.
REQ-022 busy  out  1  a MUL or DIV-class operation is iterating.

Function
REQ-023 Operand A SHALL be fwd_data[i] for the lowest index i with fwd_en[i]=1, fwd_addr[i]=in_rs1_addr and fwd_addr[i]!=0; otherwise A SHALL be in_rs1_val.
REQ-024 Forwarding for operand B SHALL follow the same rule using in_rs2_addr, and SHALL be bypassed entirely when in_use_imm=1.
REQ-025 Forwarding SHALL be sampled only in the acceptance cycle; operands SHALL be latched at acceptance.
REQ-026 in_ready SHALL equal (state==IDLE) & (!out_valid | out_ready) & !flush.
REQ-027 A request SHALL be accepted on a cycle with in_valid & in_ready.
REQ-028 The state machine SHALL have three states:
- IDLE: on accept of op 0-9 or 11, load the output register and stay in IDLE; on accept of op 10 or 12-15, go to CALC.
- CALC: count XLEN iterations, one bit per cycle (shift-add multiply, restoring divide on magnitudes).
- CALC to DONE: after the last iteration; DONE loads the output register and returns to IDLE next cycle.
REQ-029 Single-cycle ops SHALL assert out_valid the cycle after acceptance (latency 1).
REQ-030 MUL and DIV-class ops SHALL assert out_valid exactly XLEN+2 cycles after acceptance.
REQ-031 Shift ops SHALL use only B[LG-1:0] as the shift amount.
REQ-032 SLT and SLTU SHALL return 1 or 0 zero-extended to XLEN.
REQ-033 PASSB SHALL return B.
REQ-034 MUL SHALL return the low XLEN bits of A*B.
REQ-035 DIV and REM SHALL be signed: quotient truncates toward zero, and the remainder takes the sign of the dividend.
REQ-036 Divide by zero SHALL yield quotient all-ones and remainder A.
REQ-037 Signed overflow (A = most-negative value, B = -1) SHALL yield quotient A and remainder 0.
REQ-038 out_valid SHALL hold, with out_result and out_rd stable, until out_ready=1; the register clears on out_valid & out_ready unless reloaded in the same cycle.
REQ-039 A new single-cycle result MAY load in the same cycle the old result is consumed (back-to-back throughput of 1 per cycle).
REQ-040 flush SHALL, on the next edge, clear out_valid, force state to IDLE and discard iteration state.
REQ-041 flush SHALL win over simultaneous acceptance and over DONE.
REQ-042 busy SHALL be 1 exactly in states CALC and DONE.

Reset
REQ-043 Reset assertion SHALL immediately force state=IDLE, out_valid=0, out_result=0, out_rd=0, busy=0, iteration counter=0, including mid-CALC.
REQ-044 in_ready SHALL be 1 on the first edge after deassertion, provided out_valid=0 and flush=0.

Verification
REQ-045 ADD, A=5 from in_rs1_val, B=imm -7 -> out_result=0xFFFF_FFFF_FFFF_FFFE one cycle later, out_valid=1.
REQ-046 rs1=3, fwd0 {en, addr 3, 0x11} and fwd1 {en, addr 3, 0x22} -> A=0x11; fwd addr 0 with en=1 is ignored, so rs1_val is used.
REQ-047 DIV -20/3 -> quotient -6 after 66 cycles; REM -> -2; DIVU x/0 -> all-ones; DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM of the same -> 0.
REQ-048 MUL 0xFFFF_FFFF_FFFF_FFFF * 3 -> 0xFFFF_FFFF_FFFF_FFFD; busy=1 throughout; in_ready=0 until completion.
REQ-049 out_ready held 0 for 5 cycles after a result -> out_result stable and in_ready=0; then out_ready=1 with a new ADD pending -> new result loads the same cycle, with no bubble.
REQ-050 flush at CALC iteration 10 -> out_valid stays 0; in_ready=1 next cycle. Reset asserted mid-CALC -> all outputs 0 immediately.
